// File: rtl/button_gesture_decoder.sv
// -----------------------------------------------------------------------------
// button_gesture_decoder
//   Classifies debounced press/release activity of one push-button into
//   gesture events (CLICK, DOUBLE, LONG, REPEAT, LONG_REL). Events are handed
//   to the consumer through a single-entry valid/ready output register. If an
//   event is generated while that register still holds an unaccepted event,
//   the new event is discarded and evt_drop_o pulses for one cycle.
//
// Ports
//   clk          in   1  system clock
//   arst_n       in   1  asynchronous reset, active-low
//   down_i       in   1  1-cycle pulse: debounced press
//   up_i         in   1  1-cycle pulse: debounced release
//   state_i      in   1  debounced level, 1 = pressed
//   evt_valid_o  out  1  event available
//   evt_code_o   out  3  1=CLICK 2=DOUBLE 3=LONG 4=REPEAT 5=LONG_REL, 0 idle
//   evt_ready_i  in   1  consumer accepts when valid & ready at posedge
//   evt_drop_o   out  1  1-cycle pulse: new event lost, slot occupied
// -----------------------------------------------------------------------------
module button_gesture_decoder #(
  parameter int unsigned DBL_GAP_CYC = 32'd5000000,
  parameter int unsigned LONG_CYC    = 32'd25000000,
  parameter int unsigned REPEAT_CYC  = 32'd5000000
) (
  input  logic       clk,
  input  logic       arst_n,
  input  logic       down_i,
  input  logic       up_i,
  input  logic       state_i,
  output logic       evt_valid_o,
  output logic [2:0] evt_code_o,
  input  logic       evt_ready_i,
  output logic       evt_drop_o
);

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) begin
      m = b;
    end else begin
      m = m;
    end
    if (c > m) begin
      m = c;
    end else begin
      m = m;
    end
    return m;
  endfunction

  localparam int unsigned MAX_CYC = max3(DBL_GAP_CYC, LONG_CYC, REPEAT_CYC);
  localparam int          CNT_W   = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 32'd1);
  localparam logic [CNT_W-1:0] DBL_LAST  = CNT_W'(DBL_GAP_CYC - 32'd1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYC - 32'd1);

  localparam logic [2:0] EVT_NONE     = 3'd0;
  localparam logic [2:0] EVT_CLICK    = 3'd1;
  localparam logic [2:0] EVT_DOUBLE   = 3'd2;
  localparam logic [2:0] EVT_LONG     = 3'd3;
  localparam logic [2:0] EVT_REPEAT   = 3'd4;
  localparam logic [2:0] EVT_LONG_REL = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PRESS1 = 3'd1,
    ST_WAIT2  = 3'd2,
    ST_PRESS2 = 3'd3,
    ST_HELD   = 3'd4
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic [CNT_W-1:0] cnt_inc_s;
  logic             release_s;
  logic             emit_s;
  logic [2:0]       emit_code_s;
  logic             evt_valid_r;
  logic [2:0]       evt_code_r;
  logic             evt_drop_r;

  // Release detection: a low level while pressed stands in for a missed up_i.
  always_comb begin
    release_s = up_i;
    if ((state_r == ST_PRESS1) || (state_r == ST_PRESS2) || (state_r == ST_HELD)) begin
      release_s = up_i | ~state_i;
    end else begin
      release_s = up_i;
    end
  end

  // Saturating increment so the counter can never wrap.
  always_comb begin
    if (cnt_r == CNT_MAX) begin
      cnt_inc_s = cnt_r;
    end else begin
      cnt_inc_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // State and counter register.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state and counter logic; release beats timeouts, re-press beats CLICK timeout.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (down_i && !release_s) begin
          state_nxt_s = ST_PRESS1;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_PRESS1: begin
        if (release_s) begin
          state_nxt_s = ST_WAIT2;
          cnt_nxt_s   = CNT_ZERO;
        end else if (cnt_r == LONG_LAST) begin
          state_nxt_s = ST_HELD;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          cnt_nxt_s = cnt_inc_s;
        end
      end
      ST_WAIT2: begin
        if (down_i && !release_s) begin
          state_nxt_s = ST_PRESS2;
          cnt_nxt_s   = CNT_ZERO;
        end else if (cnt_r == DBL_LAST) begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          cnt_nxt_s = cnt_inc_s;
        end
      end
      ST_PRESS2: begin
        if (release_s) begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          state_nxt_s = ST_PRESS2;
        end
      end
      ST_HELD: begin
        if (release_s) begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = CNT_ZERO;
        end else if (cnt_r == REP_LAST) begin
          cnt_nxt_s = CNT_ZERO;
        end else begin
          cnt_nxt_s = cnt_inc_s;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
  end

  // Event generation, decoded from the same conditions as the transitions.
  always_comb begin
    emit_s      = 1'b0;
    emit_code_s = EVT_NONE;
    case (state_r)
      ST_PRESS1: begin
        if (!release_s && (cnt_r == LONG_LAST)) begin
          emit_s      = 1'b1;
          emit_code_s = EVT_LONG;
        end else begin
          emit_s = 1'b0;
        end
      end
      ST_WAIT2: begin
        if (!(down_i && !release_s) && (cnt_r == DBL_LAST)) begin
          emit_s      = 1'b1;
          emit_code_s = EVT_CLICK;
        end else begin
          emit_s = 1'b0;
        end
      end
      ST_PRESS2: begin
        if (release_s) begin
          emit_s      = 1'b1;
          emit_code_s = EVT_DOUBLE;
        end else begin
          emit_s = 1'b0;
        end
      end
      ST_HELD: begin
        if (release_s) begin
          emit_s      = 1'b1;
          emit_code_s = EVT_LONG_REL;
        end else if (cnt_r == REP_LAST) begin
          emit_s      = 1'b1;
          emit_code_s = EVT_REPEAT;
        end else begin
          emit_s = 1'b0;
        end
      end
      default: begin
        emit_s      = 1'b0;
        emit_code_s = EVT_NONE;
      end
    endcase
  end

  // Single-entry output slot: load when empty or being accepted, else drop the new event.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      evt_valid_r <= 1'b0;
      evt_code_r  <= EVT_NONE;
      evt_drop_r  <= 1'b0;
    end else if (emit_s) begin
      if (!evt_valid_r || evt_ready_i) begin
        evt_valid_r <= 1'b1;
        evt_code_r  <= emit_code_s;
        evt_drop_r  <= 1'b0;
      end else begin
        evt_drop_r  <= 1'b1;
      end
    end else begin
      evt_drop_r <= 1'b0;
      if (evt_valid_r && evt_ready_i) begin
        evt_valid_r <= 1'b0;
        evt_code_r  <= EVT_NONE;
      end else begin
        evt_valid_r <= evt_valid_r;
      end
    end
  end

  assign evt_valid_o = evt_valid_r;
  assign evt_code_o  = evt_code_r;
  assign evt_drop_o  = evt_drop_r;

endmodule

// File: tb/tb_button_gesture_decoder.sv
// -----------------------------------------------------------------------------
// tb_button_gesture_decoder
//   Directed bench. Gestures are planned as press/release edge numbers; a
//   gesture-level model turns each plan into a table of (edge -> event code)
//   using the timing rules, and a slot model applies valid/ready/drop rules.
//   Outputs are compared against the model on every falling clock edge, and
//   a few hand-computed literal expectations pin the model.
// -----------------------------------------------------------------------------
module tb_button_gesture_decoder;

  localparam int DBL = 8;
  localparam int LNG = 20;
  localparam int REP = 6;

  logic       clk = 1'b0;
  logic       arst_n;
  logic       down_i;
  logic       up_i;
  logic       state_i;
  logic       evt_ready_i;
  logic       evt_valid_o;
  logic [2:0] evt_code_o;
  logic       evt_drop_o;

  int n_vec  = 0;
  int n_miss = 0;
  int edge_n = 0;

  int exp_emit[int];

  logic       m_v;
  logic [2:0] m_code;
  logic       m_drop;

  button_gesture_decoder #(
    .DBL_GAP_CYC(DBL),
    .LONG_CYC   (LNG),
    .REPEAT_CYC (REP)
  ) dut (
    .clk        (clk),
    .arst_n     (arst_n),
    .down_i     (down_i),
    .up_i       (up_i),
    .state_i    (state_i),
    .evt_valid_o(evt_valid_o),
    .evt_code_o (evt_code_o),
    .evt_ready_i(evt_ready_i),
    .evt_drop_o (evt_drop_o)
  );

  always #5 clk = ~clk;

  // Count rising edges; edge k is the k-th posedge.
  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, exp, edge_n);
    end
  endtask

  // Gesture-level timing rules. p/r = press/release edges, p2/r2 optional
  // second press/release (p2 < 0 means none).
  function automatic void sched(input int p, input int r, input int p2, input int r2);
    if (r > p + LNG) begin
      exp_emit[p + LNG] = 3;
      for (int t = p + LNG + REP; t < r; t += REP) exp_emit[t] = 4;
      exp_emit[r] = 5;
    end else if (p2 > r && p2 <= r + DBL) begin
      exp_emit[r2] = 2;
    end else begin
      exp_emit[r + DBL] = 1;
    end
  endfunction

  // Output slot model.
  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      m_v    <= 1'b0;
      m_code <= 3'd0;
      m_drop <= 1'b0;
    end else if (exp_emit.exists(edge_n + 1)) begin
      if (!m_v || evt_ready_i) begin
        m_v    <= 1'b1;
        m_code <= 3'(exp_emit[edge_n + 1]);
        m_drop <= 1'b0;
      end else begin
        m_drop <= 1'b1;
      end
    end else begin
      m_drop <= 1'b0;
      if (m_v && evt_ready_i) begin
        m_v    <= 1'b0;
        m_code <= 3'd0;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    chk("valid", {31'd0, evt_valid_o}, {31'd0, m_v});
    chk("code",  {29'd0, evt_code_o},  {29'd0, m_code});
    chk("drop",  {31'd0, evt_drop_o},  {31'd0, m_drop});
  end

  // Return at the falling edge that follows edge e.
  task automatic goto(input int e);
    while (edge_n < e) @(negedge clk);
  endtask

  task automatic press_at(input int e);
    goto(e - 1);
    down_i  = 1'b1;
    state_i = 1'b1;
    @(negedge clk);
    down_i  = 1'b0;
  endtask

  task automatic release_at(input int e);
    goto(e - 1);
    up_i    = 1'b1;
    state_i = 1'b0;
    @(negedge clk);
    up_i    = 1'b0;
  endtask

  task automatic level_drop_at(input int e);
    goto(e - 1);
    state_i = 1'b0;
  endtask

  int p, r, p2, r2;

  initial begin
    arst_n      = 1'b1;
    down_i      = 1'b0;
    up_i        = 1'b0;
    state_i     = 1'b0;
    evt_ready_i = 1'b1;
    #2 arst_n = 1'b0;
    #1;
    chk("rst_valid", {31'd0, evt_valid_o}, 32'd0);
    chk("rst_code",  {29'd0, evt_code_o},  32'd0);
    chk("rst_drop",  {31'd0, evt_drop_o},  32'd0);
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);

    // 1: short press, no re-press -> CLICK DBL edges after release
    p = edge_n + 3; r = p + 5;
    sched(p, r, -1, -1);
    press_at(p); release_at(r);
    goto(r + 8);
    chk("s1_click_valid", {31'd0, evt_valid_o}, 32'd1);
    chk("s1_click_code",  {29'd0, evt_code_o},  32'd1);
    goto(r + 9);
    chk("s1_click_gone",  {31'd0, evt_valid_o}, 32'd0);
    goto(r + 12);

    // 2: press, release, re-press 3 later, release -> single DOUBLE
    p = edge_n + 3; r = p + 4; p2 = r + 3; r2 = p2 + 4;
    sched(p, r, p2, r2);
    press_at(p); release_at(r); press_at(p2); release_at(r2);
    goto(r2);
    chk("s2_double_code", {29'd0, evt_code_o}, 32'd2);
    goto(r2 + 12);

    // 3: hold 40 -> LONG, REPEATs, LONG_REL
    p = edge_n + 3; r = p + 40;
    sched(p, r, -1, -1);
    press_at(p);
    goto(p + 20); chk("s3_long",   {29'd0, evt_code_o}, 32'd3);
    goto(p + 21); chk("s3_long_1cyc", {31'd0, evt_valid_o}, 32'd0);
    goto(p + 26); chk("s3_rep1",   {29'd0, evt_code_o}, 32'd4);
    goto(p + 32); chk("s3_rep2",   {29'd0, evt_code_o}, 32'd4);
    release_at(r);
    goto(r); chk("s3_long_rel", {29'd0, evt_code_o}, 32'd5);
    goto(r + 4);

    // 4: consumer stalled: LONG held, later events dropped
    evt_ready_i = 1'b0;
    p = edge_n + 3; r = p + 40;
    sched(p, r, -1, -1);
    press_at(p);
    goto(p + 26);
    chk("s4_drop",      {31'd0, evt_drop_o},  32'd1);
    chk("s4_held_code", {29'd0, evt_code_o},  32'd3);
    goto(p + 27);
    chk("s4_drop_1cyc", {31'd0, evt_drop_o},  32'd0);
    release_at(r);
    goto(p + 45);
    chk("s4_still_long", {29'd0, evt_code_o}, 32'd3);
    evt_ready_i = 1'b1;
    goto(p + 46);
    chk("s4_accepted", {31'd0, evt_valid_o}, 32'd0);
    goto(p + 50);

    // 5: level falls with no up pulse -> treated as release
    p = edge_n + 3; r = p + 4;
    sched(p, r, -1, -1);
    press_at(p); level_drop_at(r);
    goto(r + 8);
    chk("s5_click", {29'd0, evt_code_o}, 32'd1);
    goto(r + 12);

    // 6: reset while HELD with LONG pending -> immediate clear, no later event
    evt_ready_i = 1'b0;
    p = edge_n + 3;
    exp_emit[p + LNG] = 3;
    press_at(p);
    goto(p + 22);
    chk("s6_pre_rst", {31'd0, evt_valid_o}, 32'd1);
    #2 arst_n = 1'b0;
    #1;
    chk("s6_rst_valid", {31'd0, evt_valid_o}, 32'd0);
    chk("s6_rst_code",  {29'd0, evt_code_o},  32'd0);
    chk("s6_rst_drop",  {31'd0, evt_drop_o},  32'd0);
    @(negedge clk);
    #2 arst_n = 1'b1;
    @(negedge clk);
    evt_ready_i = 1'b1;
    release_at(edge_n + 3);
    goto(edge_n + 30);
    // fresh click proves the decoder is back in IDLE
    p = edge_n + 3; r = p + 2;
    sched(p, r, -1, -1);
    press_at(p); release_at(r);
    goto(r + 8);
    chk("s6_click_after", {29'd0, evt_code_o}, 32'd1);
    goto(r + 12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
